// File: rtl/router_fifo.sv
// Per-port output FIFO of the 1x3 router. Entries carry a header tag so the read side
// can track packet length and idle the output bus after the parity byte.
module router_fifo #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    // Header length field is [WIDTH-1:2]; one extra bit holds length + parity.
    localparam int unsigned PktW = WIDTH - 1;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [DEPTH-1:0]  tag_q;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [PktW-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [WIDTH-1:0]  data_out_q, data_out_d;

    logic              wr_ok, rd_ok;
    logic [ADDR_W-1:0] wr_idx, rd_idx;
    logic [WIDTH-1:0]  rd_byte;
    logic              rd_tag;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

    assign wr_ok    = write_enb && !full;
    assign rd_ok    = read_enb && !empty;
    assign wr_idx   = wr_ptr_q[ADDR_W-1:0];
    assign rd_idx   = rd_ptr_q[ADDR_W-1:0];
    assign rd_byte  = mem_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign data_out = data_out_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pkt_cnt_d  = pkt_cnt_q;
        data_out_d = data_out_q;
        if (soft_reset) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            pkt_cnt_d  = '0;
            data_out_d = '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_d   = rd_ptr_q + 1'b1;
                data_out_d = rd_byte;
                if (rd_tag) begin
                    pkt_cnt_d = {1'b0, rd_byte[WIDTH-1:2]} + PktW'(1);
                end else if (pkt_cnt_q != '0) begin
                    pkt_cnt_d = pkt_cnt_q - PktW'(1);
                end
            end else if (pkt_cnt_q == '0) begin
                // Drive an idle bus once the packet's parity byte has gone out.
                data_out_d = '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pkt_cnt_q  <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pkt_cnt_q  <= pkt_cnt_d;
            data_out_q <= data_out_d;
        end
    end

    // Tags are reset so a stale header mark can never survive a hard reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_q <= '0;
        end else if (wr_ok && !soft_reset) begin
            tag_q[wr_idx] <= lfd_state;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_ok && !soft_reset) begin
            mem_q[wr_idx] <= data_in;
        end
    end

endmodule
